mem_access_arbiter: RTL

- Sequences all main-memory accesses through the memory address register (MAR).
- Arbitrates between two requesters, instruction fetch (port F) and data load/store (port D), and grants one transaction at a time.
- For the granted transaction: loads the address into the MAR, holds memory read/write enable for a fixed latency, captures read data, then returns a one-cycle ack.
- Sits between the control unit/fetch stage and the MAR + memory pair.

---
 rtl/mem_access_arbiter_if.sv | 32 +++
 rtl/mem_access_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: requester and memory bus bundle for mem_access_arbiter
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              MAA_f_req;
    logic [ADDR_W-1:0] MAA_f_addr;
    logic              MAA_f_ack;
    logic              MAA_d_req;
    logic              MAA_d_we;
    logic [ADDR_W-1:0] MAA_d_addr;
    logic [DATA_W-1:0] MAA_d_wdata;
    logic              MAA_d_ack;
    logic [DATA_W-1:0] MAA_rdata;
    logic              MAA_busy;
    logic [ADDR_W-1:0] MAA_mar_addr;
    logic              MAA_mar_wr_en;
    logic              MAA_mem_rd_en;
    logic              MAA_mem_wr_en;
    logic [DATA_W-1:0] MAA_mem_wdata;
    logic [DATA_W-1:0] MAA_mem_rdata;
    modport slave (
        input  MAA_f_req, MAA_f_addr, MAA_d_req, MAA_d_we, MAA_d_addr, MAA_d_wdata, MAA_mem_rdata,
        output MAA_f_ack, MAA_d_ack, MAA_rdata, MAA_busy, MAA_mar_addr, MAA_mar_wr_en,
               MAA_mem_rd_en, MAA_mem_wr_en, MAA_mem_wdata
    );
    modport master (
        output MAA_f_req, MAA_f_addr, MAA_d_req, MAA_d_we, MAA_d_addr, MAA_d_wdata, MAA_mem_rdata,
        input  MAA_f_ack, MAA_d_ack, MAA_rdata, MAA_busy, MAA_mar_addr, MAA_mar_wr_en,
               MAA_mem_rd_en, MAA_mem_wr_en, MAA_mem_wdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: sequences fetch/data memory accesses through the MAR (MAA_ROUND_ROBIN_EN selects round-robin arbitration)
module mem_access_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 2
) (
    input logic                MAA_clk,
    input logic                MAA_rst,
    mem_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ACCESS, RESP} state_t;
    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              gnt_d_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mar_wr_en_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              f_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              pick_d;
`ifdef MAA_ROUND_ROBIN_EN
    logic              last_d_q;
    assign pick_d = bus.MAA_d_req && (!bus.MAA_f_req || !last_d_q);
`else
    assign pick_d = bus.MAA_d_req;
`endif
    assign bus.MAA_busy      = state_q != IDLE;
    assign bus.MAA_mar_addr  = addr_q;
    assign bus.MAA_mar_wr_en = mar_wr_en_q;
    assign bus.MAA_mem_rd_en = rd_en_q;
    assign bus.MAA_mem_wr_en = wr_en_q;
    assign bus.MAA_mem_wdata = mem_wdata_q;
    assign bus.MAA_f_ack     = f_ack_q;
    assign bus.MAA_d_ack     = d_ack_q;
    assign bus.MAA_rdata     = rdata_q;
    // Transaction FSM; every bus output is registered alongside the state it belongs to
    always_ff @(posedge MAA_clk) begin
        if (MAA_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_d_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mar_wr_en_q <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            mem_wdata_q <= '0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            rdata_q     <= '0;
`ifdef MAA_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.MAA_f_req || bus.MAA_d_req) begin
                    gnt_d_q     <= pick_d;
                    we_q        <= pick_d && bus.MAA_d_we;
                    addr_q      <= pick_d ? bus.MAA_d_addr : bus.MAA_f_addr;
                    wdata_q     <= bus.MAA_d_wdata;
                    mar_wr_en_q <= 1'b1;
                    state_q     <= LOAD;
`ifdef MAA_ROUND_ROBIN_EN
                    last_d_q    <= pick_d;
`endif
                end
                LOAD: begin
                    mar_wr_en_q <= 1'b0;
                    rd_en_q     <= !we_q;
                    wr_en_q     <= we_q;
                    mem_wdata_q <= we_q ? wdata_q : '0;
                    cnt_q       <= 4'(MEM_LATENCY - 1);
                    state_q     <= ACCESS;
                end
                ACCESS: if (cnt_q == '0) begin
                    rd_en_q     <= 1'b0;
                    wr_en_q     <= 1'b0;
                    mem_wdata_q <= '0;
                    rdata_q     <= we_q ? rdata_q : bus.MAA_mem_rdata;
                    f_ack_q     <= !gnt_d_q;
                    d_ack_q     <= gnt_d_q;
                    state_q     <= RESP;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                default: begin
                    f_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
